ifu_redirect_ctrl: RTL and testbench
====================================

# ifu_redirect_ctrl

Front-end redirect sequencer for the instruction fetch unit. It arbitrates PC redirect requests from the backend (mispredict/exception) and from IF3 (predecode branch correction), and drives the same-cycle flush lines for the fetch stages. It holds a redirect pending while the PC register is stalled by the I-cache or instruction buffer, then issues a single registered redirect pulse to IF0. It sits beside the fetch control unit and also keeps saturating redirect statistics.

## Interface
- PC_WIDTH, 32, width of redirect target PCs
- CNT_WIDTH, 16, width of each statistics counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- be_redirect_valid  in  1  backend redirect request, single-cycle
- be_redirect_pc  in  PC_WIDTH  backend target PC
- if3_redirect_valid  in  1  IF3 correction request, single-cycle
- if3_redirect_pc  in  PC_WIDTH  IF3 target PC
- icache_busy  in  1  I-cache pause request (refill in progress)
- ibuf_full  in  1  instruction buffer pause request
- flush_front  out  1  flush to I-cache and IF2/IF3 pipeline registers
- flush_back  out  1  flush to IF3 output registers and instruction buffer
- redirect_valid  out  1  registered one-cycle PC load strobe to IF0
- redirect_pc  out  PC_WIDTH  PC to load; meaningful only with redirect_valid
- pc_hold  out  1  high while a redirect is pending; IF0 must not advance PC or issue fetches
- be_cnt, if3_cnt, drop_cnt  out  CNT_WIDTH each  accepted backend, accepted IF3, and discarded IF3 requests

## Operation
- pc_ready = !icache_busy && !ibuf_full (combinational).
- Flushes are combinational and unregistered: flush_front = be_redirect_valid || if3_redirect_valid; flush_back = be_redirect_valid. They are asserted in the request cycle regardless of FSM state.
- Arbitration in the same cycle: backend wins. A simultaneous IF3 request is discarded (drop_cnt++).
- The FSM has two states, RUN and HOLD. pend_pc and pend_src (BE/IF3) are registers.
- RUN, accepted request (winner PC):
  - if pc_ready, stay in RUN and load redirect_valid=1 / redirect_pc for the next cycle;
  - otherwise latch pend_pc/pend_src and go to HOLD.
- HOLD, no new request:
  - if pc_ready, issue pend_pc (redirect_valid next cycle) and go to RUN;
  - otherwise stay in HOLD.
- HOLD, new backend request: it always overwrites pend_pc (pend_src=BE). The issue-or-stay rule above applies in the same cycle using the new PC.
- HOLD, new IF3 request:
  - with pend_src=BE, the IF3 request is discarded (drop_cnt++);
  - with pend_src=IF3, the new IF3 request overwrites the pending one.
  - The issue-or-stay rule then applies as above.
- pc_hold = (state==HOLD).
- redirect_valid is high for exactly one cycle per issued redirect; it is otherwise 0. redirect_pc holds its last value while redirect_valid=0.
- Counters: be_cnt increments per backend request, and if3_cnt per IF3 request that is not discarded. All counters saturate at all-ones and never wrap.

## Timing
- Reset (rst high at an edge): state=RUN, redirect_valid=0, redirect_pc=0, pend_pc=0, all counters=0. pc_hold=0 from the following cycle. A pending redirect is dropped by reset. While rst is high, flush_front/flush_back still follow their inputs combinationally.
- Latency: request in cycle t with pc_ready=1 gives flush in t and redirect_valid in t+1.
- Stalled request: a request in t with pc_ready=0 gives pc_hold from t+1. If pc_ready first returns in cycle t+k, redirect_valid is in t+k+1 and pc_hold falls in t+k+1.
- Back-to-back redirects are allowed. A request in the cycle that redirect_valid is high is handled normally and produces a second pulse.
- At most one redirect is pending at any time. No request is lost except by the discard rules above.

## Test plan
- Backend redirect, PC 0xBFC0_0100, pc_ready=1 in t -> flush_front=flush_back=1 in t; redirect_valid=1 with PC 0xBFC0_0100 in t+1 only; be_cnt=1.
- Simultaneous BE 0x8000_0000 and IF3 0x8000_0040 -> flush_back=1; redirect_pc=0x8000_0000 in t+1; drop_cnt=1; if3_cnt=0.
- IF3 redirect 0x100 with icache_busy=1 for 5 cycles -> pc_hold high t+1..t+5; redirect_valid with 0x100 at t+6; flush_back stays 0 throughout.
- HOLD with pending IF3 0x100, backend 0x200 arrives while ibuf_full=1, then a later IF3 0x300 -> 0x300 discarded; single redirect_valid with 0x200 after ibuf_full drops.
- rst asserted while in HOLD -> no redirect_valid afterward; pc_hold=0 and counters=0 after reset.
- 2^CNT_WIDTH+3 backend requests -> be_cnt saturates at all-ones, no wrap.

Source files
------------

// File: rtl/ifu_redirect_ctrl.sv
// ifu_redirect_ctrl
// Front-end redirect sequencer for the instruction fetch unit. It arbitrates
// backend (mispredict/exception) and IF3 (predecode correction) redirect
// requests. It drives the same-cycle flush lines to the fetch stages, and it
// holds one redirect pending while the PC register is stalled. The redirect
// is then issued to IF0 as a single registered pulse. The block also keeps
// saturating statistics counters.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   be_redirect_*       backend redirect request (valid + target PC)
//   if3_redirect_*      IF3 correction request (valid + target PC)
//   icache_busy         I-cache refill pause
//   ibuf_full           instruction buffer pause
//   flush_front         combinational flush to I-cache and IF2/IF3 registers
//   flush_back          combinational flush to IF3 outputs and instruction buffer
//   redirect_valid/pc   registered one-cycle PC load strobe and target to IF0
//   pc_hold             a redirect is pending; IF0 must not advance
//   be_cnt/if3_cnt/drop_cnt  accepted backend, accepted IF3, discarded IF3
module ifu_redirect_ctrl #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 be_redirect_valid,
  input  logic [PC_WIDTH-1:0]  be_redirect_pc,
  input  logic                 if3_redirect_valid,
  input  logic [PC_WIDTH-1:0]  if3_redirect_pc,
  input  logic                 icache_busy,
  input  logic                 ibuf_full,
  output logic                 flush_front,
  output logic                 flush_back,
  output logic                 redirect_valid,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 pc_hold,
  output logic [CNT_WIDTH-1:0] be_cnt,
  output logic [CNT_WIDTH-1:0] if3_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  // pend_src encoding: 1 = backend, 0 = IF3
  localparam logic SRC_BE  = 1'b1;
  localparam logic SRC_IF3 = 1'b0;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    if (en && (v != {CNT_WIDTH{1'b1}})) return v + CNT_WIDTH'(1);
    return v;
  endfunction

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pend_pc_q, pend_pc_d;
  logic                  pend_src_q, pend_src_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [PC_WIDTH-1:0]   redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0]  be_cnt_q, be_cnt_d;
  logic [CNT_WIDTH-1:0]  if3_cnt_q, if3_cnt_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic                  pc_ready;
  logic                  if3_drop;
  logic                  if3_take;
  logic                  cand_valid;
  logic [PC_WIDTH-1:0]   cand_pc;
  logic                  cand_src;

  // Flushes bypass the FSM entirely so they still follow requests during reset
  assign flush_front = be_redirect_valid || if3_redirect_valid;
  assign flush_back  = be_redirect_valid;

  always_comb begin
    pc_ready = !icache_busy && !ibuf_full;

    // IF3 loses to a same-cycle backend request and to a pending backend one
    if3_drop = if3_redirect_valid &&
               (be_redirect_valid || (state_q == HOLD && pend_src_q == SRC_BE));
    if3_take = if3_redirect_valid && !if3_drop;

    // Candidate is the new winner if any, otherwise whatever is pending.
    // In RUN nothing is pending, so the candidate exists only with a request.
    cand_valid = be_redirect_valid || if3_take || (state_q == HOLD);
    if (be_redirect_valid) begin
      cand_pc  = be_redirect_pc;
      cand_src = SRC_BE;
    end else if (if3_take) begin
      cand_pc  = if3_redirect_pc;
      cand_src = SRC_IF3;
    end else begin
      cand_pc  = pend_pc_q;
      cand_src = pend_src_q;
    end

    state_d          = state_q;
    pend_pc_d        = pend_pc_q;
    pend_src_d       = pend_src_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    if (cand_valid) begin
      if (pc_ready) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = cand_pc;
        state_d          = RUN;
      end else begin
        pend_pc_d  = cand_pc;
        pend_src_d = cand_src;
        state_d    = HOLD;
      end
    end

    be_cnt_d   = sat_inc(be_cnt_q, be_redirect_valid);
    if3_cnt_d  = sat_inc(if3_cnt_q, if3_take);
    drop_cnt_d = sat_inc(drop_cnt_q, if3_drop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      pend_pc_q        <= '0;
      pend_src_q       <= SRC_IF3;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      be_cnt_q         <= '0;
      if3_cnt_q        <= '0;
      drop_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      pend_pc_q        <= pend_pc_d;
      pend_src_q       <= pend_src_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      be_cnt_q         <= be_cnt_d;
      if3_cnt_q        <= if3_cnt_d;
      drop_cnt_q       <= drop_cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign pc_hold        = (state_q == HOLD);
  assign be_cnt         = be_cnt_q;
  assign if3_cnt        = if3_cnt_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_ifu_redirect_ctrl.sv
// Testbench for ifu_redirect_ctrl: directed scenarios plus randomized traffic,
// all checked against a pending-slot reference model kept in this file.
module tb_ifu_redirect_ctrl;

  localparam int PW = 32;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          be_v, if3_v, busy, full;
  logic [PW-1:0] be_pc, if3_pc;
  logic          flush_front, flush_back, redirect_valid, pc_hold;
  logic [PW-1:0] redirect_pc;
  logic [CW-1:0] be_cnt, if3_cnt, drop_cnt;

  ifu_redirect_ctrl #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk                (clk),
    .rst                (rst),
    .be_redirect_valid  (be_v),
    .be_redirect_pc     (be_pc),
    .if3_redirect_valid (if3_v),
    .if3_redirect_pc    (if3_pc),
    .icache_busy        (busy),
    .ibuf_full          (full),
    .flush_front        (flush_front),
    .flush_back         (flush_back),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .pc_hold            (pc_hold),
    .be_cnt             (be_cnt),
    .if3_cnt            (if3_cnt),
    .drop_cnt           (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: at most one pending redirect lives in a queue
  typedef struct {
    logic [PW-1:0] pc;
    bit            is_be;
  } redir_t;

  redir_t        m_pend[$];
  bit            m_rv;
  logic [PW-1:0] m_rpc;
  int            m_be, m_if3, m_drop;

  function automatic int sat(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic model_cycle(input bit r, input bit b, input logic [PW-1:0] bp,
                             input bit i, input logic [PW-1:0] ip, input bit ready);
    redir_t acc;
    bit     have_acc;
    if (r) begin
      m_pend.delete();
      m_rv = 0; m_rpc = '0; m_be = 0; m_if3 = 0; m_drop = 0;
      return;
    end
    have_acc = 0;
    if (b) begin
      acc.pc = bp; acc.is_be = 1; have_acc = 1;
      m_be = sat(m_be);
      if (i) m_drop = sat(m_drop);
    end else if (i) begin
      if (m_pend.size() != 0 && m_pend[0].is_be) m_drop = sat(m_drop);
      else begin
        acc.pc = ip; acc.is_be = 0; have_acc = 1;
        m_if3 = sat(m_if3);
      end
    end
    if (have_acc) begin
      m_pend.delete();
      m_pend.push_back(acc);
    end
    m_rv = 0;
    if (m_pend.size() != 0 && ready) begin
      m_rv  = 1;
      m_rpc = m_pend[0].pc;
      m_pend.delete();
    end
  endtask

  // One clock: drive at negedge, check flushes, then check registered outputs
  task automatic step(input bit r, input bit b, input logic [PW-1:0] bp,
                      input bit i, input logic [PW-1:0] ip,
                      input bit bz, input bit fl, input bit do_chk);
    @(negedge clk);
    rst = r; be_v = b; be_pc = bp; if3_v = i; if3_pc = ip; busy = bz; full = fl;
    #1;
    if (do_chk) begin
      chk("flush_front", 64'(flush_front), 64'(b | i));
      chk("flush_back",  64'(flush_back),  64'(b));
    end
    @(posedge clk);
    model_cycle(r, b, bp, i, ip, !bz && !fl);
    #1;
    if (do_chk) begin
      chk("redirect_valid", 64'(redirect_valid), 64'(m_rv));
      chk("redirect_pc",    64'(redirect_pc),    64'(m_rpc));
      chk("pc_hold",        64'(pc_hold),        64'(m_pend.size() != 0));
      chk("be_cnt",         64'(be_cnt),         64'(m_be));
      chk("if3_cnt",        64'(if3_cnt),        64'(m_if3));
      chk("drop_cnt",       64'(drop_cnt),       64'(m_drop));
    end
  endtask

  task automatic idle(input int n, input bit bz, input bit fl);
    for (int k = 0; k < n; k++) step(0, 0, '0, 0, '0, bz, fl, 1);
  endtask

  initial begin
    rst = 1; be_v = 0; if3_v = 0; be_pc = '0; if3_pc = '0; busy = 0; full = 0;
    m_rv = 0; m_rpc = '0; m_be = 0; m_if3 = 0; m_drop = 0;

    // Reset state, with flushes still following their inputs during reset
    step(1, 0, '0, 0, '0, 0, 0, 1);
    step(1, 1, 32'h1234, 1, 32'h5678, 0, 0, 1);
    step(1, 0, '0, 0, '0, 0, 0, 1);
    chk("reset_pc_hold", 64'(pc_hold), 64'd0);
    chk("reset_be_cnt",  64'(be_cnt),  64'd0);

    // Backend redirect with PC ready: pulse in the next cycle only
    step(0, 1, 32'hBFC0_0100, 0, '0, 0, 0, 1);
    chk("be_pulse_pc", 64'(redirect_pc), 64'h0000_0000_BFC0_0100);
    idle(2, 0, 0);

    // Simultaneous requests: backend wins, IF3 discarded
    step(0, 1, 32'h8000_0000, 1, 32'h8000_0040, 0, 0, 1);
    chk("arb_pc",   64'(redirect_pc), 64'h0000_0000_8000_0000);
    chk("arb_drop", 64'(drop_cnt),    64'd1);
    idle(1, 0, 0);

    // IF3 redirect stalled by I-cache for 5 cycles
    step(0, 0, '0, 1, 32'h100, 1, 0, 1);
    idle(4, 1, 0);
    idle(1, 0, 0);
    chk("stall_pc_hold_fall", 64'(pc_hold), 64'd0);
    chk("stall_pulse", 64'(redirect_valid), 64'd1);
    idle(2, 0, 0);

    // HOLD with pending IF3, then backend overwrite, then IF3 discarded
    step(0, 0, '0, 1, 32'h100, 0, 1, 1);
    step(0, 1, 32'h200, 0, '0, 0, 1, 1);
    step(0, 0, '0, 1, 32'h300, 0, 1, 1);
    idle(2, 0, 1);
    idle(1, 0, 0);
    chk("hold_ovr_pc", 64'(redirect_pc), 64'h200);
    idle(3, 0, 0);

    // HOLD with pending IF3 overwritten by a newer IF3
    step(0, 0, '0, 1, 32'h400, 1, 1, 1);
    step(0, 0, '0, 1, 32'h440, 1, 0, 1);
    idle(1, 0, 0);
    chk("if3_ovr_pc", 64'(redirect_pc), 64'h440);

    // Back-to-back redirects, second one in the pulse cycle
    step(0, 1, 32'h1000, 0, '0, 0, 0, 1);
    step(0, 0, '0, 1, 32'h2000, 0, 0, 1);
    idle(1, 0, 0);

    // Reset while holding: the pending redirect must vanish
    step(0, 1, 32'h3000, 0, '0, 1, 0, 1);
    step(1, 0, '0, 0, '0, 0, 0, 1);
    idle(4, 0, 0);
    chk("rst_hold_cnt", 64'(be_cnt), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 15), {$urandom(), 2'b00} >> 2 << 2,
           ($urandom_range(0, 99) < 20), {$urandom(), 2'b00} >> 2 << 2,
           ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 20), 1);
    end

    // Counter saturation: 2^CW+3 backend requests from zero
    step(1, 0, '0, 0, '0, 0, 0, 1);
    for (int n = 0; n < CNT_MAX + 4; n++)
      step(0, 1, 32'(n << 2), 0, '0, 0, 0, (n > CNT_MAX - 3));
    chk("be_cnt_sat", 64'(be_cnt), 64'(16'hFFFF));
    chk("if3_cnt_sat_idle", 64'(if3_cnt), 64'd0);
    idle(2, 0, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
